// File: rtl/fpsr_btn_conditioner.sv
// fpsr_btn_conditioner
//   Five-channel pushbutton conditioner feeding the first_person_second_row
//   game FSM. Each channel passes through a two-flop synchronizer and a
//   counter-based debounce FSM. It produces a debounced level (DPB) and a
//   single-cycle enable pulse per accepted press (SCEN). With auto-repeat
//   built in, it also produces repeat pulses (MCEN).
//
//   Optional feature macro: FPSR_BTN_REPEAT_EN
//     defined   -> per-channel auto-repeat counter drives MCEN
//     undefined -> no repeat logic, MCEN is constant 0
//
//   Ports (top):
//     Clk    in  1  system clock, all flops on the rising edge
//     Reset  in  1  asynchronous active-high reset
//     PB     in  5  raw buttons {BtnD, BtnU, BtnR, BtnL, BtnC}, async to Clk
//     DPB    out 5  debounced level per channel
//     SCEN   out 5  one-cycle pulse per accepted press
//     MCEN   out 5  auto-repeat pulses (0 unless FPSR_BTN_REPEAT_EN)
//
//   Ports (fpsr_btn_lane, one channel):
//     i_clk, i_rst, i_pb -> o_dpb, o_scen, o_mcen

module fpsr_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb,
  output logic o_dpb,
  output logic o_scen,
  output logic o_mcen
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Bit 1 of the state code is set exactly in PRESSED and RELEASE_WAIT.
  // That bit is the debounced level, so DPB comes straight off a flop.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_PWAIT   = 2'b01;
  localparam logic [1:0] ST_PRESSED = 2'b10;
  localparam logic [1:0] ST_RWAIT   = 2'b11;

  logic          r_s1, r_s2;
  logic [1:0]    r_st;
  logic [CW-1:0] r_cnt;
  logic          r_scen;

  logic w_cnt_hit;
  logic w_press_acc;

  assign w_cnt_hit   = (r_cnt == CNT_MAX);
  assign w_press_acc = (r_st == ST_PWAIT) && r_s2 && w_cnt_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_scen <= 1'b0;
    end else begin
      r_s1   <= i_pb;
      r_s2   <= r_s1;
      r_scen <= w_press_acc;
      // The counter is cleared on every state change and only counts in the
      // wait states. It therefore stops at CNT_MAX and never wraps.
      case (r_st)
        ST_IDLE: begin
          if (r_s2) begin
            r_st  <= ST_PWAIT;
            r_cnt <= '0;
          end
        end
        ST_PWAIT: begin
          if (!r_s2) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
          end else if (w_cnt_hit) begin
            r_st  <= ST_PRESSED;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!r_s2) begin
            r_st  <= ST_RWAIT;
            r_cnt <= '0;
          end
        end
        default: begin
          // A bounce on release goes back to PRESSED without a new SCEN.
          if (r_s2) begin
            r_st  <= ST_PRESSED;
            r_cnt <= '0;
          end else if (w_cnt_hit) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign o_dpb  = r_st[1];
  assign o_scen = r_scen;

`ifdef FPSR_BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] RD_MAX = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_MAX = RCW'(REPEAT_PERIOD - 1);
  localparam logic [RCW-1:0] R_ONE  = RCW'(1);

  logic [RCW-1:0] r_rcnt;
  logic           r_rphase;  // 0: waiting out REPEAT_DELAY, 1: periodic phase
  logic           r_mcen;

  logic w_hold;
  logic w_rel_done;

  assign w_hold     = (r_st == ST_PRESSED) && r_s2;
  assign w_rel_done = (r_st == ST_RWAIT) && !r_s2 && w_cnt_hit;

  // The count advances only while the button stays in PRESSED. In
  // RELEASE_WAIT it is frozen, so a release bounce resumes where it left off.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b0;
      r_mcen   <= 1'b0;
    end else begin
      r_mcen <= 1'b0;
      if (w_press_acc) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b0;
        r_mcen   <= 1'b1;
      end else if (w_hold) begin
        if (!r_rphase && r_rcnt == RD_MAX) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b1;
          r_mcen   <= 1'b1;
        end else if (r_rphase && r_rcnt == RP_MAX) begin
          r_rcnt <= '0;
          r_mcen <= 1'b1;
        end else begin
          r_rcnt <= r_rcnt + R_ONE;
        end
      end else if (w_rel_done) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b0;
      end
    end
  end

  assign o_mcen = r_mcen;
`else
  assign o_mcen = 1'b0;
`endif

endmodule

module fpsr_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] PB,
  output logic [4:0] DPB,
  output logic [4:0] SCEN,
  output logic [4:0] MCEN
);

  localparam int NUM_CH = 5;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    fpsr_btn_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_lane (
      .i_clk  (Clk),
      .i_rst  (Reset),
      .i_pb   (PB[g]),
      .o_dpb  (DPB[g]),
      .o_scen (SCEN[g]),
      .o_mcen (MCEN[g])
    );
  end

endmodule

// File: tb/tb_fpsr_btn_conditioner.sv
module tb_fpsr_btn_conditioner;

  logic       Clk;
  logic       Reset;
  logic [4:0] PB;
  logic [4:0] DPB, SCEN, MCEN;

  fpsr_btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .PB    (PB),
    .DPB   (DPB),
    .SCEN  (SCEN),
    .MCEN  (MCEN)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Event kinds on the scoreboard
  localparam int K_SC = 0;
  localparam int K_MC = 1;
  localparam int K_RI = 2;
  localparam int K_FA = 3;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] ch;
    int         cyc;
  } ev_t;

  // One row: a PB waveform (bit i = value driven in slot i) applied to every
  // channel in mask. Expected event cycles are offsets from the first slot;
  // -1 / 8'hFF means the event must not happen.
  typedef struct packed {
    logic [4:0]      mask;
    logic [31:0]     pat;
    int              len;
    int              scen;
    int              rise;
    int              fall;
    logic [4:0][7:0] mc;
  } vec_t;

  ev_t        sb[$];
  vec_t       tbl[8];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         ev_cnt = 0;
  logic       mon_en = 1'b0;
  logic [4:0] prev_dpb = '0;

  function automatic string kname(input int k);
    case (k)
      K_SC:    return "SCEN";
      K_MC:    return "MCEN";
      K_RI:    return "DPB-rise";
      default: return "DPB-fall";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic push(input int kind, input int ch, input int c);
    ev_t e;
    e.kind = 2'(kind);
    e.ch   = 3'(ch);
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic match(input int kind, input int ch);
    int idx = -1;
    ev_cnt++;
    foreach (sb[i])
      if (idx < 0 && int'(sb[i].kind) == kind && int'(sb[i].ch) == ch) idx = i;
    if (idx < 0) begin
      n_chk++;
      $display("FAIL unexpected %s ch%0d: seen at cycle %0d, expected none", kname(kind), ch, cyc);
    end else begin
      chk($sformatf("%s ch%0d cycle", kname(kind), ch), cyc, sb[idx].cyc);
      sb.delete(idx);
    end
  endtask

  // Monitor: runs on the falling edge, away from the active edge
  always @(negedge Clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (SCEN[ch])                   match(K_SC, ch);
        if (MCEN[ch])                   match(K_MC, ch);
        if (DPB[ch] && !prev_dpb[ch])   match(K_RI, ch);
        if (!DPB[ch] && prev_dpb[ch])   match(K_FA, ch);
      end
    end
    prev_dpb <= DPB;
  end

  task automatic run_row(input vec_t v, input int r);
    int c0, ev0, n;
    @(negedge Clk);
    c0  = cyc;
    ev0 = ev_cnt;
    n   = 0;
    for (int ch = 0; ch < 5; ch++) begin
      if (v.mask[ch]) begin
        if (v.scen >= 0) begin push(K_SC, ch, c0 + v.scen); n++; end
        for (int j = 0; j < 5; j++)
          if (v.mc[j] != 8'hFF) begin push(K_MC, ch, c0 + int'(v.mc[j])); n++; end
        if (v.rise >= 0) begin push(K_RI, ch, c0 + v.rise); n++; end
        if (v.fall >= 0) begin push(K_FA, ch, c0 + v.fall); n++; end
      end
    end
    for (int i = 0; i <= v.len; i++) begin
      if (i > 0) @(negedge Clk);
      for (int ch = 0; ch < 5; ch++)
        if (v.mask[ch]) PB[ch] = (i < v.len) ? v.pat[i] : 1'b0;
    end
    repeat (14) @(negedge Clk);
    chk($sformatf("row%0d event count", r), ev_cnt - ev0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k, ev0, n;
    Reset = 1'b1;
    PB    = '0;

    //             mask      pattern        len scen rise fall mcen offsets
    tbl[0] = '{5'b00001, 32'h01FF_FFFF, 25,  7,  7, 32, {5{8'hFF}}};  // clean press
    tbl[1] = '{5'b00010, 32'h000F_FFF5, 20, 11, 11, 27, {5{8'hFF}}};  // bouncy press
    tbl[2] = '{5'b00100, 32'h0000_0007,  3, -1, -1, -1, {5{8'hFF}}};  // short glitch
    tbl[3] = '{5'b01000, 32'h0000_33FF, 14,  7,  7, 21, {5{8'hFF}}};  // release bounce
    tbl[4] = '{5'b01000, 32'h0000_00FF,  8,  7,  7, 15, {5{8'hFF}}};  // fresh re-press
    tbl[5] = '{5'b00011, 32'h0000_00FF,  8,  7,  7, 15, {5{8'hFF}}};  // simultaneous
    tbl[6] = '{5'b10000, 32'h0000_001F,  5,  7,  7, 12, {5{8'hFF}}};  // shortest accepted
    tbl[7] = '{5'b10000, 32'h0000_000F,  4, -1, -1, -1, {5{8'hFF}}};  // one slot too short
`ifdef FPSR_BTN_REPEAT_EN
    tbl[0].mc = {8'd26, 8'd23, 8'd20, 8'd17, 8'd7};
    tbl[1].mc = {8'hFF, 8'hFF, 8'hFF, 8'd21, 8'd11};
    tbl[3].mc = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7};
    tbl[4].mc = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7};
    tbl[5].mc = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7};
    tbl[6].mc = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd7};
`endif

    #2;
    chk("reset DPB",  int'(DPB),  0);
    chk("reset SCEN", int'(SCEN), 0);
    chk("reset MCEN", int'(MCEN), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    mon_en = 1'b1;
    repeat (2) @(negedge Clk);

    for (int r = 0; r < 8; r++) run_row(tbl[r], r);

    // Reset asserted mid-press on channel 4 with the button still held
    @(negedge Clk);
    c0  = cyc;
    ev0 = ev_cnt;
    n   = 2;
    PB[4] = 1'b1;
    push(K_SC, 4, c0 + 7);
    push(K_RI, 4, c0 + 7);
`ifdef FPSR_BTN_REPEAT_EN
    push(K_MC, 4, c0 + 7);
    n++;
`endif
    repeat (10) @(negedge Clk);
    chk("pre-reset DPB[4]", int'(DPB[4]), 1);
    mon_en = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("async reset DPB",  int'(DPB),  0);
    chk("async reset SCEN", int'(SCEN), 0);
    chk("async reset MCEN", int'(MCEN), 0);
    @(negedge Clk);
    Reset = 1'b0;
    k = cyc;
    push(K_SC, 4, k + 7);
    push(K_RI, 4, k + 7);
    n += 2;
`ifdef FPSR_BTN_REPEAT_EN
    push(K_MC, 4, k + 7);
    n++;
`endif
    @(negedge Clk);
    mon_en = 1'b1;
    repeat (7) @(negedge Clk);
    PB[4] = 1'b0;
    push(K_FA, 4, k + 15);
    n++;
    repeat (12) @(negedge Clk);
    chk("reset row event count", ev_cnt - ev0, n);

    chk("scoreboard leftovers", sb.size(), 0);
    foreach (sb[i])
      $display("  missing %s ch%0d at cycle %0d", kname(int'(sb[i].kind)), sb[i].ch, sb[i].cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpsr_btn_conditioner.md
# fpsr_btn_conditioner

Five-channel button conditioner between the raw board pushbuttons and the `first_person_second_row` game FSM. Each channel has four stages: a two-flop synchronizer, a counter-based debouncer, a debounced level output, and a single-clock enable pulse (SCEN) per press. The SCEN outputs drive the `Start`, `Ack` and `BtnC/L/R/U/D` inputs of the game FSM. With this block in place, a held or bouncing button registers as exactly one action.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 50_000_000: cycles from press acceptance to the first auto-repeat pulse. Used only with the macro.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent auto-repeat pulses. Used only with the macro.

- `Clk` in 1: system clock (`sys_clk`, 100 MHz). All flops are on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `PB` in 5: raw buttons, bit order {BtnD, BtnU, BtnR, BtnL, BtnC} = [4:0]. Active-high and asynchronous to `Clk`.
- `DPB` out 5: debounced button level per channel.
- `SCEN` out 5: one-cycle pulse per accepted press.
- `MCEN` out 5: auto-repeat enable pulses (see Configuration).

## Operation
- The 5 channels are independent and identical. All outputs are registered.
- **Synchronizer:** `s1 <= PB`, then `s2 <= s1`. The FSM and counters use only `s2`.
- **Per-channel state:** a 2-bit FSM plus a counter of width `$clog2(DEBOUNCE_CYCLES)`.
- **FSM states and transitions:**
  - IDLE: if `s2`=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - `s2`=0: go to IDLE, cnt=0.
    - `s2`=1 and cnt==`DEBOUNCE_CYCLES`-1: go to PRESSED and set SCEN=1.
    - Otherwise: cnt+1.
  - PRESSED: if `s2`=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - `s2`=1: return to PRESSED with cnt=0. No SCEN; this is bounce on release.
    - `s2`=0 and cnt==`DEBOUNCE_CYCLES`-1: go to IDLE.
    - Otherwise: cnt+1.
- **DPB:** 1 exactly while the FSM is in PRESSED or RELEASE_WAIT.
- **SCEN:** 1 for exactly the single cycle after the PRESS_WAIT→PRESSED edge, and 0 in all other cycles. Only a full IDLE→PRESSED path can produce another pulse.
- **Counter:** never exceeds `DEBOUNCE_CYCLES`-1. It is cleared on every state change, so it has no wrap-around.

## Timing
- Reset values: `s1`, `s2`, `DPB`, `SCEN`, `MCEN` and all counters are 0. Every FSM is in IDLE.
- Press latency: take edge 0 as the first edge that samples `PB`=1, held stable. Then `s2`=1 after edge 1, PRESS_WAIT after edge 2, and `SCEN`/`DPB` rise after edge `DEBOUNCE_CYCLES`+2.
- Release latency: `DPB` falls after edge `DEBOUNCE_CYCLES`+2, measured from the first edge that samples `PB`=0.
- Glitches: a press glitch shorter than `DEBOUNCE_CYCLES` cycles (at `s2`) produces no `DPB` or `SCEN` activity.
- Simultaneous presses: channels may pulse `SCEN` in the same cycle. There is no arbitration.
- Reset asserted mid-operation: all outputs go to 0 immediately, without waiting for a clock edge. After deassertion, a still-held button is treated as a new press and produces `SCEN` after `DEBOUNCE_CYCLES`+2 edges.
- The game FSM consumes `SCEN` directly on the same `Clk`. No handshake is needed because pulses are single-cycle.

## Configuration
- Macro: `FPSR_BTN_REPEAT_EN`.
- **Defined:** each channel adds a repeat counter of width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`.
  - `MCEN` pulses for one cycle:
    - coincident with `SCEN`;
    - again `REPEAT_DELAY` cycles later;
    - then every `REPEAT_PERIOD` cycles while the FSM stays in PRESSED.
  - The repeat counter is cleared on entry from PRESS_WAIT and holds its value in RELEASE_WAIT.
  - Bounce back to PRESSED resumes the count without restarting.
  - Leaving to IDLE clears the counter.
- **Undefined:** no repeat logic is generated and `MCEN` is a constant 0.
- Either way, the `DPB` and `SCEN` behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4. Repeat tests use `REPEAT_DELAY`=10 and `REPEAT_PERIOD`=3.
- **Clean press:** `PB[0]` steps 0→1 and is held 20 cycles → `SCEN[0]`=1 for exactly one cycle after edge 6. `DPB[0]`=1 from edge 6 onward. Other bits stay 0.
- **Bouncy press:** `PB[1]` toggles 1,0,1,0 on single cycles, then holds 1 → only one `SCEN[1]` pulse, 6 edges after the final rise.
- **Glitch rejection:** `PB[2]`=1 for 3 cycles, then 0 → `DPB[2]` and `SCEN[2]` stay 0 throughout.
- **Release bounce and re-press:**
  - Hold `PB[3]`, release with 2-cycle bounce back to 1, release again → `DPB[3]` stays 1 through the bounce and no second `SCEN`.
  - A fresh press after `DPB`=0 → new `SCEN`.
- **Reset mid-press:** assert `Reset` while `DPB[4]`=1 with `PB[4]` still held → all outputs 0 immediately. After deassertion, `SCEN[4]` pulses once 6 edges later.
- **`FPSR_BTN_REPEAT_EN` with `PB[0]` held:** `MCEN[0]` pulses at the `SCEN` cycle, +10, +13 and +16 cycles. With the macro undefined, `MCEN` stays 0.
